axi_rd_burst_ctrl: RTL and testbench
====================================

// Module: axi_rd_burst_ctrl
// PURPOSE
// Sequences one AXI4 read master port for a byte-count read command {address, bytes}.
// - Splits each command into INCR bursts, capped at MAX_BEATS and never crossing a 4 KB boundary.
// - Streams R data out and returns one aggregated response per command.
// - Sits between the video/frame fetch logic and the AXI interconnect; one burst outstanding at a time.
// PARAMETERS
// DATA_W    32  AXI data width in bits (8..1024, power of 2); BPB = DATA_W/8 bytes per beat
// MAX_BEATS 256 maximum beats per burst (1..256, power of 2)
// PORTS
// aclk          in   1       clock, all logic rising-edge
// aresetn       in   1       asynchronous active-low reset
// cmd_valid     in   1       command valid
// cmd_ready     out  1       command accepted when cmd_valid && cmd_ready
// cmd_addr      in   32      start byte address
// cmd_bytes     in   16      byte count
// sts_valid     out  1       one-cycle pulse: command finished
// sts_resp      out  2       aggregated response (OKAY/EXOKAY/SLVERR/DECERR encoding)
// dout_valid    out  1       read data valid
// dout_ready    in   1       downstream ready
// dout_data     out  DATA_W  read data
// dout_last     out  1       final beat of the command
// m_araddr      out  32      AR address
// m_arlen       out  8       AR beats-1
// m_arsize      out  3       constant log2(BPB)
// m_arburst     out  2       constant INCR (2'b01)
// m_arvalid     out  1       AR valid
// m_arready     in   1       AR ready
// m_rdata       in   DATA_W  R data
// m_rresp       in   2       R response
// m_rlast       in   1       R last
// m_rvalid      in   1       R valid
// m_rready      out  1       R ready
// BEHAVIOUR
// - Reset (async on aresetn low): state IDLE; cmd_ready=1; m_arvalid=0; m_araddr=0; m_arlen=0;
//   sts_valid=0; sts_resp=OKAY; internal counters=0. Reset mid-burst aborts silently, no sts pulse.
// - FSM: IDLE -> AR -> R -> (AR | DONE) -> IDLE.
// - IDLE: cmd_ready=1. On accept, latch addr; beats_left = ceil(bytes/BPB) (17-bit math); resp_acc=OKAY.
//   - bytes==0: -> DONE, sts_resp=OKAY, no AR issued.
//   - addr[log2(BPB)-1:0]!=0: -> DONE, sts_resp=SLVERR, no AR issued.
//   - otherwise -> AR.
// - AR: burst = min(beats_left, MAX_BEATS, (4096 - addr[11:0])/BPB).
//   - m_arlen = burst-1; m_araddr = current addr; m_arvalid registered high on entry.
//   - ARVALID is held with AR fields stable until m_arready; then -> R.
// - R: m_rready = dout_ready; dout_valid = m_rvalid; dout_data = m_rdata (combinational pass-through).
//   - Each R handshake decrements beats_left.
//   - dout_last = m_rvalid && m_rlast && (beats_left==1).
//   - Response merge: resp_acc takes the first SLVERR/DECERR seen and keeps it (sticky); EXOKAY is treated as OKAY.
//   - On the m_rlast handshake: addr += burst*BPB; then -> DONE if beats_left becomes 0, else -> AR.
//   - m_rlast arriving early or late is not checked; burst end is taken from m_rlast only.
// - DONE: sts_valid=1 for exactly one cycle; sts_resp=resp_acc; -> IDLE (cmd_ready=1 next cycle).
// - Latency: cmd accept -> m_arvalid next cycle; last R beat -> sts_valid next cycle.
// - Outside R: m_rready=0, dout_valid=0.
// - Address arithmetic wraps modulo 2^32; the 4 KB split guarantees no burst crosses 0xFFFFF000.
// TESTING
// 1. DATA_W=32: cmd addr 0x1000, bytes 64 -> one AR araddr 0x1000 arlen 15 arsize 2 arburst 1;
//    16 dout beats, dout_last on 16th only; sts OKAY.
// 2. 4 KB split: addr 0x0FF0, bytes 32 -> AR 0x0FF0 len 3, then AR 0x1000 len 3; one sts pulse, OKAY.
// 3. MAX_BEATS=16, addr 0x2000, bytes 100 (25 beats) -> AR 0x2000 len 15, AR 0x2040 len 8; dout_last on beat 25.
// 4. rresp=SLVERR on beat 3 of 8, DECERR on beat 6 -> all 8 beats forwarded; sts_resp=SLVERR.
// 5. Edge commands: addr 0x1002 -> sts SLVERR next cycle, no AR; bytes 0 -> sts OKAY, no AR.
// 6. Stalls and reset: dout_ready and m_arready toggled randomly -> AR fields stable while arvalid and no beat lost;
//    aresetn low mid-R -> all outputs at reset values immediately; next command completes normally.

Source files
------------

// File: rtl/axi_rd_burst_ctrl.sv
// AXI4 read burst sequencer: splits a {addr, bytes} command into INCR bursts that respect
// MAX_BEATS and 4 KB pages, streams R data downstream and reports one merged response per command.
module axi_rd_burst_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BEATS = 256
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [31:0]       cmd_addr,
  input  logic [15:0]       cmd_bytes,
  output logic              sts_valid,
  output logic [1:0]        sts_resp,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_last,
  output logic [31:0]       m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready
);

  localparam int unsigned Bpb = DATA_W / 8;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {StIdle, StAr, StR, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic        arvalid_q, arvalid_d;
  logic [16:0] beats_q, beats_d;
  logic [8:0]  burst_q, burst_d;
  logic [1:0]  resp_q, resp_d;

  logic [16:0] cmd_beats;
  logic        cmd_misaligned;
  logic [16:0] beats_dec;
  logic [31:0] nxt_addr;
  logic [16:0] nxt_beats;
  logic [12:0] page_bytes;
  logic [16:0] page_beats;
  logic [16:0] burst_c;
  logic        load_ar;

  assign cmd_beats      = (17'(cmd_bytes) + 17'(Bpb - 1)) / 17'(Bpb);
  assign cmd_misaligned = (cmd_addr & 32'(Bpb - 1)) != 32'd0;
  // Saturate so a late m_rlast cannot underflow the beat counter.
  assign beats_dec      = (beats_q != 17'd0) ? beats_q - 17'd1 : 17'd0;

  // Size of the next burst, computed for whichever address/beat count the AR will be loaded from.
  always_comb begin
    if (state_q == StIdle) begin
      nxt_addr  = cmd_addr;
      nxt_beats = cmd_beats;
    end else begin
      nxt_addr  = araddr_q + 32'(burst_q) * 32'(Bpb);
      nxt_beats = beats_dec;
    end
    page_bytes = 13'd4096 - {1'b0, nxt_addr[11:0]};
    page_beats = 17'(page_bytes) / 17'(Bpb);
    burst_c    = nxt_beats;
    if (page_beats < burst_c) burst_c = page_beats;
    if (17'(MAX_BEATS) < burst_c) burst_c = 17'(MAX_BEATS);
  end

  always_comb begin
    state_d    = state_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    arvalid_d  = arvalid_q;
    beats_d    = beats_q;
    burst_d    = burst_q;
    resp_d     = resp_q;
    load_ar    = 1'b0;
    cmd_ready  = 1'b0;
    sts_valid  = 1'b0;
    m_rready   = 1'b0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          resp_d  = RespOkay;
          beats_d = cmd_beats;
          if (cmd_bytes == 16'd0) begin
            state_d = StDone;
          end else if (cmd_misaligned) begin
            resp_d  = RespSlverr;
            state_d = StDone;
          end else begin
            load_ar = 1'b1;
            state_d = StAr;
          end
        end
      end
      StAr: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          state_d   = StR;
        end
      end
      StR: begin
        m_rready   = dout_ready;
        dout_valid = m_rvalid;
        dout_last  = m_rvalid && m_rlast && (beats_q == 17'd1);
        if (m_rvalid && dout_ready) begin
          beats_d = beats_dec;
          // First error wins; EXOKAY folds into OKAY.
          if (!resp_q[1] && m_rresp[1]) resp_d = m_rresp;
          if (m_rlast) begin
            if (beats_dec == 17'd0) begin
              state_d = StDone;
            end else begin
              load_ar = 1'b1;
              state_d = StAr;
            end
          end
        end
      end
      StDone: begin
        sts_valid = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (load_ar) begin
      araddr_d  = nxt_addr;
      arlen_d   = 8'(burst_c - 17'd1);
      burst_d   = 9'(burst_c);
      arvalid_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      araddr_q  <= 32'd0;
      arlen_q   <= 8'd0;
      arvalid_q <= 1'b0;
      beats_q   <= 17'd0;
      burst_q   <= 9'd0;
      resp_q    <= RespOkay;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
      beats_q   <= beats_d;
      burst_q   <= burst_d;
      resp_q    <= resp_d;
    end
  end

  assign m_araddr  = araddr_q;
  assign m_arlen   = arlen_q;
  assign m_arvalid = arvalid_q;
  assign m_arsize  = 3'($clog2(Bpb));
  assign m_arburst = 2'b01;
  assign sts_resp  = resp_q;
  assign dout_data = m_rdata;

endmodule

// File: tb/tb_axi_rd_burst_ctrl.sv
// Randomized bench for axi_rd_burst_ctrl: a behavioural split/merge model predicts ARs, beats and
// the final response while the bench plays the AXI slave and the downstream consumer.
module tb_axi_rd_burst_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned MB = 16;

  logic          aclk, aresetn;
  logic          cmd_valid, cmd_ready;
  logic [31:0]   cmd_addr;
  logic [15:0]   cmd_bytes;
  logic          sts_valid;
  logic [1:0]    sts_resp;
  logic          dout_valid, dout_ready, dout_last;
  logic [DW-1:0] dout_data;
  logic [31:0]   m_araddr;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst;
  logic          m_arvalid, m_arready;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rlast, m_rvalid, m_rready;

  axi_rd_burst_ctrl #(.DATA_W(DW), .MAX_BEATS(MB)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_bytes(cmd_bytes),
    .sts_valid(sts_valid), .sts_resp(sts_resp),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data), .dout_last(dout_last),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  task automatic check_reset_outputs();
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check_eq("rst_arvalid", 64'(m_arvalid), 64'd0);
    check_eq("rst_araddr", 64'(m_araddr), 64'd0);
    check_eq("rst_arlen", 64'(m_arlen), 64'd0);
    check_eq("rst_sts_valid", 64'(sts_valid), 64'd0);
    check_eq("rst_sts_resp", 64'(sts_resp), 64'd0);
    check_eq("rst_dout_valid", 64'(dout_valid), 64'd0);
    check_eq("rst_rready", 64'(m_rready), 64'd0);
  endtask

  // err1 gets SLVERR, err2 gets DECERR (beat indices from 0, -1 = none); abort_at resets mid-R.
  task automatic run_cmd(input logic [31:0] addr, input int bytes, input int err1, input int err2,
                         input int abort_at, input bit stall);
    ar_t         exp_ar[$];
    ar_t         e;
    logic [31:0] data_plan[$];
    logic [1:0]  resp_plan[$];
    logic [1:0]  exp_resp;
    logic [1:0]  r;
    logic [31:0] a;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;
    int          total, left, b, page;
    int          beat_idx, burst_left;
    bit          done, arv_prev, hs_prev, sts_due;

    total    = 0;
    exp_resp = 2'b00;
    if (bytes != 0 && addr[1:0] != 2'b00) begin
      exp_resp = 2'b10;
    end else if (bytes != 0) begin
      total = (bytes + 3) / 4;
      a     = addr;
      left  = total;
      while (left > 0) begin
        page = (4096 - int'(a[11:0])) / 4;
        b    = left;
        if (b > int'(MB)) b = int'(MB);
        if (page < b) b = page;
        exp_ar.push_back('{addr: a, len: 8'(b - 1)});
        a    = a + 32'(b * 4);
        left = left - b;
      end
      for (int i = 0; i < total; i++) begin
        data_plan.push_back($urandom);
        if (i == err1)      r = 2'b10;
        else if (i == err2) r = 2'b11;
        else                r = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b00;
        resp_plan.push_back(r);
        if (exp_resp == 2'b00 && r[1]) exp_resp = r;
      end
    end

    @(negedge aclk);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_bytes = 16'(bytes);
    #1 check_eq("cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge aclk);
    cmd_valid = 1'b0;

    if (total == 0) begin
      #1;
      check_eq("edge_sts_valid", 64'(sts_valid), 64'd1);
      check_eq("edge_sts_resp", 64'(sts_resp), 64'(exp_resp));
      check_eq("edge_no_ar", 64'(m_arvalid), 64'd0);
      @(negedge aclk);
      #1;
      check_eq("edge_sts_once", 64'(sts_valid), 64'd0);
      check_eq("edge_cmd_ready", 64'(cmd_ready), 64'd1);
      return;
    end

    beat_idx   = 0;
    burst_left = 0;
    done       = 1'b0;
    arv_prev   = 1'b0;
    hs_prev    = 1'b0;
    sts_due    = 1'b0;
    prev_addr  = '0;
    prev_len   = '0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (cyc > 0) @(negedge aclk);
      if (hs_prev) m_rvalid = 1'b0;
      hs_prev    = 1'b0;
      m_arready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      dout_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (burst_left > 0 && !m_rvalid && (!stall || $urandom_range(0, 2) != 0)) begin
        m_rvalid = 1'b1;
        m_rdata  = data_plan[beat_idx];
        m_rresp  = resp_plan[beat_idx];
        m_rlast  = (burst_left == 1);
      end
      #1;
      if (cyc == 0) check_eq("ar_latency", 64'(m_arvalid), 64'd1);
      if (sts_due) begin
        check_eq("sts_latency", 64'(sts_valid), 64'd1);
        check_eq("sts_resp", 64'(sts_resp), 64'(exp_resp));
        check_eq("sts_beats", 64'(beat_idx), 64'(total));
        check_eq("sts_ars_left", 64'(exp_ar.size()), 64'd0);
        done = 1'b1;
      end else if (sts_valid) begin
        check_eq("sts_early", 64'd1, 64'd0);
        done = 1'b1;
      end
      if (m_arvalid) begin
        if (arv_prev) begin
          check_eq("ar_addr_stable", 64'(m_araddr), 64'(prev_addr));
          check_eq("ar_len_stable", 64'(m_arlen), 64'(prev_len));
        end
        if (m_arready) begin
          arv_prev = 1'b0;
          if (exp_ar.size() == 0) begin
            check_eq("ar_unexpected", 64'd1, 64'd0);
          end else begin
            e = exp_ar.pop_front();
            check_eq("araddr", 64'(m_araddr), 64'(e.addr));
            check_eq("arlen", 64'(m_arlen), 64'(e.len));
            check_eq("arsize", 64'(m_arsize), 64'd2);
            check_eq("arburst", 64'(m_arburst), 64'd1);
            burst_left = int'(e.len) + 1;
          end
        end else begin
          arv_prev  = 1'b1;
          prev_addr = m_araddr;
          prev_len  = m_arlen;
        end
      end else begin
        arv_prev = 1'b0;
      end
      check_eq("dout_valid", 64'(dout_valid), 64'(m_rvalid));
      if (m_rvalid) begin
        check_eq("dout_data", 64'(dout_data), 64'(data_plan[beat_idx]));
        check_eq("rready", 64'(m_rready), 64'(dout_ready));
        if (dout_ready) begin
          check_eq("dout_last", 64'(dout_last), 64'(beat_idx == total - 1));
          beat_idx++;
          burst_left--;
          hs_prev = 1'b1;
          if (beat_idx == total) sts_due = 1'b1;
        end
      end
      if (abort_at >= 0 && beat_idx >= abort_at && !done) begin
        aresetn  = 1'b0;
        m_rvalid = 1'b1;
        #1;
        check_reset_outputs();
        m_rvalid  = 1'b0;
        m_arready = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        return;
      end
    end
    if (!done) begin
      check_eq("timeout", 64'd0, 64'd1);
      return;
    end
    m_rvalid = 1'b0;
    @(negedge aclk);
    #1;
    check_eq("sts_once", 64'(sts_valid), 64'd0);
    check_eq("idle_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] ra;
    int          rb, re1;
    aresetn    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_bytes  = '0;
    dout_ready = 1'b0;
    m_arready  = 1'b0;
    m_rdata    = '0;
    m_rresp    = 2'b00;
    m_rlast    = 1'b0;
    m_rvalid   = 1'b0;
    #12;
    check_reset_outputs();
    @(negedge aclk);
    aresetn = 1'b1;

    run_cmd(32'h0000_1000, 64, -1, -1, -1, 1'b0);
    run_cmd(32'h0000_0FF0, 32, -1, -1, -1, 1'b0);
    run_cmd(32'h0000_2000, 100, -1, -1, -1, 1'b0);
    run_cmd(32'h0000_4000, 32, 2, 5, -1, 1'b0);
    run_cmd(32'h0000_1002, 16, -1, -1, -1, 1'b0);
    run_cmd(32'h0000_1000, 0, -1, -1, -1, 1'b0);
    run_cmd(32'hFFFF_FFC0, 128, -1, -1, -1, 1'b1);
    run_cmd(32'h0000_5000, 64, -1, -1, -1, 1'b1);
    run_cmd(32'h0000_3000, 64, -1, -1, 5, 1'b1);
    run_cmd(32'h0000_3000, 64, -1, -1, -1, 1'b1);

    for (int n = 0; n < 14; n++) begin
      ra = ($urandom & 32'hFFFF_F000) | 32'(4096 - 4 * $urandom_range(1, 40));
      if ($urandom_range(0, 7) == 0) ra = ra | 32'd1;
      rb  = $urandom_range(1, 400);
      re1 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, rb / 4)) : -1;
      run_cmd(ra, rb, re1, -1, -1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
